control_unit: RTL and testbench



---
 rtl/control_unit.sv | 271 +++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: RV32I+F instruction decode with a single registered output bank.
// Decodes opcode/funct3/funct7/rs2 into datapath, memory and FPU controls;
// anything not recognised decodes as an all-zero NOP with regEnable low.
// Build option: define T07_FPU_EN to decode the single-precision FP opcodes.
// Without it every FP opcode is illegal and the FPU outputs are tied to 0.
module control_unit (
    input  logic       clk,
    input  logic       nRst,
    input  logic [6:0] Op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [4:0] rs2,
    output logic [3:0] ALUOp,
    output logic       ALUSrc,
    output logic       regWrite,
    output logic       branch,
    output logic       jump,
    output logic       memWrite,
    output logic       memRead,
    output logic [3:0] memOp,
    output logic [2:0] regWriteSrc,
    output logic       regEnable,
    output logic [4:0] FPUOp,
    output logic [2:0] FPURnd,
    output logic [1:0] FPUWrite,
    output logic       FPUSrc,
    output logic [4:0] rs3
);
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    localparam logic [2:0] WB_ALU   = 3'd0;
    localparam logic [2:0] WB_MEM   = 3'd1;
    localparam logic [2:0] WB_PC4   = 3'd2;
    localparam logic [2:0] WB_IMM   = 3'd3;
    localparam logic [2:0] WB_PCIMM = 3'd4;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       regwrite;
        logic       branch;
        logic       jump;
        logic       memwrite;
        logic       memread;
        logic [3:0] memop;
        logic [2:0] regwritesrc;
        logic       regenable;
        logic [4:0] fpuop;
        logic [2:0] fpurnd;
        logic [1:0] fpuwrite;
        logic       fpusrc;
        logic [4:0] rs3;
    } ctrl_t;

    ctrl_t dec_p0;
    ctrl_t ctrl_p1;

    // Shift-immediates constrain funct7; sub/sra are the only funct7=0100000 R-types.
    logic imm_ok;
    logic op_ok;
    assign imm_ok = (funct3 == 3'b001) ? (funct7 == 7'b0000000) :
                    (funct3 == 3'b101) ? (funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b1;
    assign op_ok  = (funct7 == 7'b0000000) ||
                    (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));

`ifdef T07_FPU_EN
    localparam logic [6:0] OP_FLW    = 7'b0000111;
    localparam logic [6:0] OP_FSW    = 7'b0100111;
    localparam logic [6:0] OP_FMADD  = 7'b1000011;
    localparam logic [6:0] OP_FMSUB  = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB = 7'b1001011;
    localparam logic [6:0] OP_FNMADD = 7'b1001111;
    localparam logic [6:0] OP_FP     = 7'b1010011;
    localparam logic [2:0] WB_FPU    = 3'd5;

    // Rounding-mode field: 101 and 110 are reserved encodings.
    function automatic logic rm_ok(input logic [2:0] rm);
        return (rm != 3'b101) && (rm != 3'b110);
    endfunction

    // Operations whose funct3 carries a rounding mode.
    function automatic logic uses_rm(input logic [4:0] fop);
        return fop inside {5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd11, 5'd12, 5'd18, 5'd19};
    endfunction

    // Operations whose result lands in the integer register file.
    function automatic logic int_dest(input logic [4:0] fop);
        return fop inside {5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17};
    endfunction

    // OP-FP sub-decode; 0 means the encoding is not recognised.
    function automatic logic [4:0] opfp_op(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] r2);
        logic [4:0] fop;
        fop = 5'd0;
        case (f7)
            7'b0000000: fop = 5'd1;
            7'b0000100: fop = 5'd2;
            7'b0001000: fop = 5'd3;
            7'b0001100: fop = 5'd4;
            7'b0101100: if (r2 == 5'd0) fop = 5'd5;
            7'b0010000: if (f3 <= 3'd2) fop = 5'd6 + {2'b00, f3};
            7'b0010100: if (f3 <= 3'd1) fop = 5'd9 + {2'b00, f3};
            7'b1100000: if (r2 <= 5'd1) fop = 5'd11 + r2;
            7'b1110000: begin
                if (r2 == 5'd0 && f3 == 3'd0) fop = 5'd13;
                else if (r2 == 5'd0 && f3 == 3'd1) fop = 5'd17;
            end
            7'b1010000: if (f3 <= 3'd2) fop = 5'd16 - {2'b00, f3};
            7'b1101000: if (r2 <= 5'd1) fop = 5'd18 + r2;
            7'b1111000: if (r2 == 5'd0 && f3 == 3'd0) fop = 5'd20;
            default:    fop = 5'd0;
        endcase
        if (uses_rm(fop) && !rm_ok(f3)) fop = 5'd0;
        return fop;
    endfunction

    logic [4:0] fp_fop;
    logic [4:0] fused_fop;
    assign fp_fop    = opfp_op(funct7, funct3, rs2);
    assign fused_fop = 5'd21 + {3'b000, Op[3:2]};
`endif

    // Stage p0: combinational decode of the current instruction fields.
    always_comb begin
        dec_p0 = '0;
        case (Op)
            OP_LUI: begin
                dec_p0.regenable   = 1'b1;
                dec_p0.regwrite    = 1'b1;
                dec_p0.alusrc      = 1'b1;
                dec_p0.regwritesrc = WB_IMM;
            end
            OP_AUIPC: begin
                dec_p0.regenable   = 1'b1;
                dec_p0.regwrite    = 1'b1;
                dec_p0.alusrc      = 1'b1;
                dec_p0.regwritesrc = WB_PCIMM;
            end
            OP_JAL: begin
                dec_p0.regenable   = 1'b1;
                dec_p0.regwrite    = 1'b1;
                dec_p0.jump        = 1'b1;
                dec_p0.regwritesrc = WB_PC4;
            end
            OP_JALR: if (funct3 == 3'b000) begin
                dec_p0.regenable   = 1'b1;
                dec_p0.regwrite    = 1'b1;
                dec_p0.jump        = 1'b1;
                dec_p0.alusrc      = 1'b1;
                dec_p0.regwritesrc = WB_PC4;
            end
            OP_BRANCH: if (funct3[2:1] != 2'b01) begin
                dec_p0.regenable = 1'b1;
                dec_p0.branch    = 1'b1;
                case (funct3[2:1])
                    2'b00:   dec_p0.aluop = 4'b1000;
                    2'b10:   dec_p0.aluop = 4'b0010;
                    default: dec_p0.aluop = 4'b0011;
                endcase
            end
            OP_LOAD: if (funct3 != 3'b011 && funct3[2:1] != 2'b11) begin
                dec_p0.regenable   = 1'b1;
                dec_p0.regwrite    = 1'b1;
                dec_p0.memread     = 1'b1;
                dec_p0.alusrc      = 1'b1;
                dec_p0.memop       = {1'b1, funct3};
                dec_p0.regwritesrc = WB_MEM;
            end
            OP_STORE: if (!funct3[2] && funct3[1:0] != 2'b11) begin
                dec_p0.regenable = 1'b1;
                dec_p0.memwrite  = 1'b1;
                dec_p0.alusrc    = 1'b1;
                dec_p0.memop     = {1'b1, funct3};
            end
            OP_IMM: if (imm_ok) begin
                dec_p0.regenable   = 1'b1;
                dec_p0.regwrite    = 1'b1;
                dec_p0.alusrc      = 1'b1;
                dec_p0.aluop       = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
                dec_p0.regwritesrc = WB_ALU;
            end
            OP_OP: if (op_ok) begin
                dec_p0.regenable   = 1'b1;
                dec_p0.regwrite    = 1'b1;
                dec_p0.aluop       = {funct7[5], funct3};
                dec_p0.regwritesrc = WB_ALU;
            end
`ifdef T07_FPU_EN
            OP_FLW: if (funct3 == 3'b010) begin
                dec_p0.regenable   = 1'b1;
                dec_p0.memread     = 1'b1;
                dec_p0.alusrc      = 1'b1;
                dec_p0.memop       = 4'b1010;
                dec_p0.regwritesrc = WB_MEM;
                dec_p0.fpuwrite    = 2'b01;
            end
            OP_FSW: if (funct3 == 3'b010) begin
                dec_p0.regenable = 1'b1;
                dec_p0.memwrite  = 1'b1;
                dec_p0.alusrc    = 1'b1;
                dec_p0.memop     = 4'b1010;
            end
            OP_FMADD, OP_FMSUB, OP_FNMSUB, OP_FNMADD:
                if (funct7[1:0] == 2'b00 && rm_ok(funct3)) begin
                    dec_p0.regenable = 1'b1;
                    dec_p0.fpuop     = fused_fop;
                    dec_p0.fpuwrite  = 2'b01;
                    dec_p0.fpurnd    = funct3;
                    dec_p0.rs3       = funct7[6:2];
                end
            OP_FP: if (fp_fop != 5'd0) begin
                dec_p0.regenable = 1'b1;
                dec_p0.fpuop     = fp_fop;
                dec_p0.fpusrc    = fp_fop inside {5'd18, 5'd19, 5'd20};
                if (uses_rm(fp_fop)) dec_p0.fpurnd = funct3;
                if (int_dest(fp_fop)) begin
                    dec_p0.fpuwrite    = 2'b10;
                    dec_p0.regwrite    = 1'b1;
                    dec_p0.regwritesrc = WB_FPU;
                end else begin
                    dec_p0.fpuwrite = 2'b01;
                end
            end
`endif
            default: dec_p0 = '0;
        endcase
    end

    // Stage p1: register the whole decode once; reset clears every output.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) ctrl_p1 <= '0;
        else       ctrl_p1 <= dec_p0;
    end

    assign ALUOp       = ctrl_p1.aluop;
    assign ALUSrc      = ctrl_p1.alusrc;
    assign regWrite    = ctrl_p1.regwrite;
    assign branch      = ctrl_p1.branch;
    assign jump        = ctrl_p1.jump;
    assign memWrite    = ctrl_p1.memwrite;
    assign memRead     = ctrl_p1.memread;
    assign memOp       = ctrl_p1.memop;
    assign regWriteSrc = ctrl_p1.regwritesrc;
    assign regEnable   = ctrl_p1.regenable;
`ifdef T07_FPU_EN
    assign FPUOp    = ctrl_p1.fpuop;
    assign FPURnd   = ctrl_p1.fpurnd;
    assign FPUWrite = ctrl_p1.fpuwrite;
    assign FPUSrc   = ctrl_p1.fpusrc;
    assign rs3      = ctrl_p1.rs3;
`else
    // Integer-only build: FPU controls are constants; rs2 and the FP register fields have no use.
    logic unused_fp;
    assign unused_fp = ^{rs2, ctrl_p1.fpuop, ctrl_p1.fpurnd, ctrl_p1.fpuwrite,
                         ctrl_p1.fpusrc, ctrl_p1.rs3};
    assign FPUOp    = 5'd0;
    assign FPURnd   = 3'd0;
    assign FPUWrite = 2'd0;
    assign FPUSrc   = 1'b0;
    assign rs3      = 5'd0;
`endif
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed scoreboard bench for control_unit.
// Expected decodes are queued as each instruction is driven and compared one
// edge later; FP expectations follow the T07_FPU_EN build option.
module tb_control_unit;
    logic       clk = 1'b0;
    logic       nRst;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [3:0] ALUOp;
    logic       ALUSrc, regWrite, branch, jump, memWrite, memRead, regEnable, FPUSrc;
    logic [3:0] memOp;
    logic [2:0] regWriteSrc, FPURnd;
    logic [4:0] FPUOp, rs3;
    logic [1:0] FPUWrite;
    logic [33:0] obs;

    int checks = 0;
    int errors = 0;
    logic [33:0] exp_q[$];
    string       tag_q[$];

    control_unit dut (
        .clk(clk), .nRst(nRst), .Op(Op), .funct3(funct3), .funct7(funct7), .rs2(rs2),
        .ALUOp(ALUOp), .ALUSrc(ALUSrc), .regWrite(regWrite), .branch(branch), .jump(jump),
        .memWrite(memWrite), .memRead(memRead), .memOp(memOp), .regWriteSrc(regWriteSrc),
        .regEnable(regEnable), .FPUOp(FPUOp), .FPURnd(FPURnd), .FPUWrite(FPUWrite),
        .FPUSrc(FPUSrc), .rs3(rs3)
    );

    always #5 clk = ~clk;

    assign obs = {ALUOp, ALUSrc, regWrite, branch, jump, memWrite, memRead, memOp,
                  regWriteSrc, regEnable, FPUOp, FPURnd, FPUWrite, FPUSrc, rs3};

    // Pack expected outputs in the same order as obs.
    function automatic logic [33:0] mk(input int aluop, input int alusrc, input int regwrite,
                                       input int br, input int jmp, input int memwr,
                                       input int memrd, input int memop, input int rws,
                                       input int regen, input int fpuop, input int rnd,
                                       input int fw, input int fsrc, input int r3);
        return {4'(aluop), 1'(alusrc), 1'(regwrite), 1'(br), 1'(jmp), 1'(memwr), 1'(memrd),
                4'(memop), 3'(rws), 1'(regen), 5'(fpuop), 3'(rnd), 2'(fw), 1'(fsrc), 5'(r3)};
    endfunction

    task automatic check_now(input string tag, input logic [33:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
    endtask

    // Drive one instruction, queue its expected decode, pop and compare after the edge.
    task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] r2, input logic [33:0] e, input string tag);
        logic [33:0] ex;
        string       tg;
        @(negedge clk);
        Op = op; funct3 = f3; funct7 = f7; rs2 = r2;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        ex = exp_q.pop_front();
        tg = tag_q.pop_front();
        check_now(tg, ex);
    endtask

    initial begin
        logic [33:0] e;
        nRst = 1'b0; Op = 7'b0110011; funct3 = 3'b000; funct7 = 7'b0000000; rs2 = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_low", '0);
        @(negedge clk);
        nRst = 1'b1;
        #1;
        check_now("reset_hold", '0);
        @(posedge clk);
        #1;
        check_now("reset_release", mk(0,0,1,0,0,0,0,0,0,1,0,0,0,0,0));

        step(7'b0110011, 3'b000, 7'b0000000, 5'd0, mk(0,0,1,0,0,0,0,0,0,1,0,0,0,0,0), "op_add");
        step(7'b0110011, 3'b000, 7'b0100000, 5'd0, mk(8,0,1,0,0,0,0,0,0,1,0,0,0,0,0), "op_sub");
        step(7'b0110011, 3'b001, 7'b0100000, 5'd0, '0, "op_bad_f7");
        step(7'b0010011, 3'b101, 7'b0100000, 5'd0, mk(13,1,1,0,0,0,0,0,0,1,0,0,0,0,0), "imm_srai");
        step(7'b0010011, 3'b000, 7'b0100000, 5'd0, mk(0,1,1,0,0,0,0,0,0,1,0,0,0,0,0), "imm_addi");
        step(7'b0000011, 3'b100, 7'b0000000, 5'd0, mk(0,1,1,0,0,0,1,12,1,1,0,0,0,0,0), "load_lbu");
        step(7'b0100011, 3'b010, 7'b0000000, 5'd0, mk(0,1,0,0,0,1,0,10,0,1,0,0,0,0,0), "store_sw");
        step(7'b0000011, 3'b011, 7'b0000000, 5'd0, '0, "load_bad_f3");
        step(7'b1101111, 3'b000, 7'b0000000, 5'd0, mk(0,0,1,0,1,0,0,0,2,1,0,0,0,0,0), "jal");
        step(7'b1100111, 3'b000, 7'b0000000, 5'd0, mk(0,1,1,0,1,0,0,0,2,1,0,0,0,0,0), "jalr");
        step(7'b1100011, 3'b110, 7'b0000000, 5'd0, mk(3,0,0,1,0,0,0,0,0,1,0,0,0,0,0), "br_bltu");
        step(7'b1100011, 3'b001, 7'b0000000, 5'd0, mk(8,0,0,1,0,0,0,0,0,1,0,0,0,0,0), "br_bne");
        step(7'b1100011, 3'b100, 7'b0000000, 5'd0, mk(2,0,0,1,0,0,0,0,0,1,0,0,0,0,0), "br_blt");
        step(7'b0110111, 3'b000, 7'b0000000, 5'd0, mk(0,1,1,0,0,0,0,0,3,1,0,0,0,0,0), "lui");
        step(7'b0010111, 3'b000, 7'b0000000, 5'd0, mk(0,1,1,0,0,0,0,0,4,1,0,0,0,0,0), "auipc");
        step(7'b1111111, 3'b111, 7'b1111111, 5'd31, '0, "op_illegal");

`ifdef T07_FPU_EN
        e = mk(0,0,1,0,0,0,0,0,5,1,12,1,2,0,0);
`else
        e = '0;
`endif
        step(7'b1010011, 3'b001, 7'b1100000, 5'd1, e, "fcvt_wu_s");
`ifdef T07_FPU_EN
        e = mk(0,0,0,0,0,0,0,0,0,1,21,2,1,0,5);
`else
        e = '0;
`endif
        step(7'b1000011, 3'b010, 7'b0010100, 5'd0, e, "fmadd");
`ifdef T07_FPU_EN
        e = mk(0,1,0,0,0,0,1,10,1,1,0,0,1,0,0);
`else
        e = '0;
`endif
        step(7'b0000111, 3'b010, 7'b0000000, 5'd0, e, "flw");
        step(7'b1010011, 3'b101, 7'b0000000, 5'd0, '0, "fadd_bad_rm");
`ifdef T07_FPU_EN
        e = mk(0,0,0,0,0,0,0,0,0,1,18,0,1,1,0);
`else
        e = '0;
`endif
        step(7'b1010011, 3'b000, 7'b1101000, 5'd0, e, "fcvt_s_w");
`ifdef T07_FPU_EN
        e = mk(0,0,1,0,0,0,0,0,5,1,14,0,2,0,0);
`else
        e = '0;
`endif
        step(7'b1010011, 3'b010, 7'b1010000, 5'd0, e, "feq");
`ifdef T07_FPU_EN
        e = mk(0,0,0,0,0,0,0,0,0,1,8,0,1,0,0);
`else
        e = '0;
`endif
        step(7'b1010011, 3'b010, 7'b0010000, 5'd0, e, "fsgnjx");

        // Reset arriving mid-cycle clears outputs at once and drops the pending decode.
        step(7'b0110111, 3'b000, 7'b0000000, 5'd0, mk(0,1,1,0,0,0,0,0,3,1,0,0,0,0,0), "lui_pre");
        @(negedge clk);
        Op = 7'b0010111;
        #1;
        nRst = 1'b0;
        #1;
        check_now("reset_async", '0);
        @(posedge clk);
        #1;
        check_now("reset_discard", '0);
        @(negedge clk);
        nRst = 1'b1;
        step(7'b1101111, 3'b000, 7'b0000000, 5'd0, mk(0,0,1,0,1,0,0,0,2,1,0,0,0,0,0), "jal_post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
